// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer for the accumulator core: owns the PC,
// gates the decoder write strobes and runs the start/done handshake.
module instr_sequencer #(
    parameter int PC_W     = 10,
    parameter int START_PC = 0,
    parameter int MEM_LAT  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            br_ctrl,
    input  logic            jmp_ctrl,
    input  logic            regwrite_ctrl,
    input  logic            memwrite_ctrl,
    input  logic [1:0]      accdata_ctrl,
    input  logic            accwrite_ctrl,
    input  logic            done_ctrl,
    input  logic            acc_true_i,
    input  logic [PC_W-1:0] tgt_addr_i,
    output logic [PC_W-1:0] pc_o,
    output logic            ir_load_o,
    output logic            regwrite_en_o,
    output logic            accwrite_en_o,
    output logic            memwrite_en_o,
    output logic            mem_req_o,
    output logic            done_o,
    output logic [15:0]     retired_o
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);
    localparam logic [3:0]      LAT_M1     = 4'(MEM_LAT - 1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ret_q, ret_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            is_lb_q, is_lb_d;

    logic            is_lb, mem_op, take_tgt;
    logic [PC_W-1:0] pc_next;
    logic [15:0]     ret_inc;

    assign is_lb    = (accdata_ctrl == 2'b10);
    assign mem_op   = is_lb | memwrite_ctrl;
    assign take_tgt = jmp_ctrl | (br_ctrl & acc_true_i);
    // pc_q + 1 naturally wraps from all-ones back to zero at PC_W bits.
    assign pc_next  = take_tgt ? tgt_addr_i : pc_q + 1'b1;
    assign ret_inc  = (ret_q == 16'hFFFF) ? ret_q : ret_q + 16'd1;

    assign pc_o      = pc_q;
    assign retired_o = ret_q;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ret_d         = ret_q;
        cnt_d         = cnt_q;
        is_lb_d       = is_lb_q;
        ir_load_o     = 1'b0;
        regwrite_en_o = 1'b0;
        accwrite_en_o = 1'b0;
        memwrite_en_o = 1'b0;
        mem_req_o     = 1'b0;
        done_o        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d    = START_ADDR;
                    ret_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_load_o = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (done_ctrl) begin
                    state_d = S_HALT;
                end else if (mem_op) begin
                    cnt_d   = LAT_M1;
                    is_lb_d = is_lb;
                    state_d = S_MEM;
                end else begin
                    regwrite_en_o = regwrite_ctrl;
                    accwrite_en_o = accwrite_ctrl;
                    pc_d          = pc_next;
                    ret_d         = ret_inc;
                    state_d       = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_o     = 1'b1;
                memwrite_en_o = ~is_lb_q;
                if (cnt_q == 4'd0) begin
                    accwrite_en_o = is_lb_q;
                    pc_d          = pc_next;
                    ret_d         = ret_inc;
                    state_d       = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HALT: begin
                done_o = 1'b1;
                if (start_i) begin
                    pc_d    = START_ADDR;
                    ret_d   = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            ret_q   <= '0;
            cnt_q   <= '0;
            is_lb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            is_lb_q <= is_lb_d;
        end
    end

endmodule
